// File: rtl/rotor_led_ctrl_if.sv
// Rotary encoder and LED display signals of rotor_led_ctrl.
// The master side (board / bench) drives the rotor inputs; the slave side (controller) drives the display.
interface rotor_led_ctrl_if;
    logic       ROT_A;
    logic       ROT_B;
    logic       ROT_CENTER;
    logic [7:0] LED;
    logic       STEP_CW;
    logic       STEP_CCW;
    logic       MODE;

    modport master (
        output ROT_A, ROT_B, ROT_CENTER,
        input  LED, STEP_CW, STEP_CCW, MODE
    );

    modport slave (
        input  ROT_A, ROT_B, ROT_CENTER,
        output LED, STEP_CW, STEP_CCW, MODE
    );
endinterface

// File: rtl/rotor_led_ctrl.sv
// Rotary encoder front end: sync + debounce, quadrature detent decode, pointer/position display.
// Define ROT_SATURATE_EN to make the position counter saturate instead of wrapping.
//
// state | meaning
// IDLE  | detent rest, {A,B}=11
// CW1   | clockwise, saw 01
// CW2   | clockwise, saw 00
// CW3   | clockwise, saw 10; 11 completes a CW step
// CCW1  | counter-clockwise, saw 10
// CCW2  | counter-clockwise, saw 00
// CCW3  | counter-clockwise, saw 01; 11 completes a CCW step
module rotor_led_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input logic             CLK50MHZ,
    input logic             RST,
    rotor_led_ctrl_if.slave rot
);

    localparam int CNT_W = 20;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CW1  = 3'd1;
    localparam logic [2:0] S_CW2  = 3'd2;
    localparam logic [2:0] S_CW3  = 3'd3;
    localparam logic [2:0] S_CCW1 = 3'd4;
    localparam logic [2:0] S_CCW2 = 3'd5;
    localparam logic [2:0] S_CCW3 = 3'd6;

    // Bit order of the input vectors: [2]=centre, [1]=B, [0]=A; idle is C=0, B=1, A=1.
    localparam logic [2:0] IN_IDLE = 3'b011;

    logic [2:0]       sync1_q, sync2_q;
    logic [2:0]       deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [2:0]       state_q, state_d;
    logic             step_cw_q, step_cw_d;
    logic             step_ccw_q, step_ccw_d;
    logic             c_prev_q, c_rise_q;
    logic [7:0]       ptr_q, ptr_d;
    logic [7:0]       pos_q, pos_d;
    logic             mode_q;
    logic [7:0]       led_q;
    logic [1:0]       ab;

    assign ab = {deb_q[0], deb_q[1]};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Illegal skips (both phases changing at once) abandon the detent without a step.
    always_comb begin
        state_d    = state_q;
        step_cw_d  = 1'b0;
        step_ccw_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ab == 2'b01)      state_d = S_CW1;
                else if (ab == 2'b10) state_d = S_CCW1;
            end
            S_CW1: begin
                if (ab == 2'b00)      state_d = S_CW2;
                else if (ab != 2'b01) state_d = S_IDLE;
            end
            S_CW2: begin
                if (ab == 2'b10)      state_d = S_CW3;
                else if (ab == 2'b01) state_d = S_CW1;
                else if (ab == 2'b11) state_d = S_IDLE;
            end
            S_CW3: begin
                if (ab == 2'b11) begin
                    state_d   = S_IDLE;
                    step_cw_d = 1'b1;
                end else if (ab == 2'b00) state_d = S_CW2;
                else if (ab == 2'b01)     state_d = S_IDLE;
            end
            S_CCW1: begin
                if (ab == 2'b00)      state_d = S_CCW2;
                else if (ab != 2'b10) state_d = S_IDLE;
            end
            S_CCW2: begin
                if (ab == 2'b01)      state_d = S_CCW3;
                else if (ab == 2'b10) state_d = S_CCW1;
                else if (ab == 2'b11) state_d = S_IDLE;
            end
            S_CCW3: begin
                if (ab == 2'b11) begin
                    state_d    = S_IDLE;
                    step_ccw_d = 1'b1;
                end else if (ab == 2'b00) state_d = S_CCW2;
                else if (ab == 2'b10)     state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        pos_d = pos_q;
        if (step_cw_q) begin
            ptr_d = {ptr_q[6:0], ptr_q[7]};
`ifdef ROT_SATURATE_EN
            if (pos_q != 8'hFF) pos_d = pos_q + 8'd1;
`else
            pos_d = pos_q + 8'd1;
`endif
        end else if (step_ccw_q) begin
            ptr_d = {ptr_q[0], ptr_q[7:1]};
`ifdef ROT_SATURATE_EN
            if (pos_q != 8'h00) pos_d = pos_q - 8'd1;
`else
            pos_d = pos_q - 8'd1;
`endif
        end
    end

    // The centre edge is delayed one extra stage so it lines up with a step decoded
    // from a phase that was debounced in the same cycle.
    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            sync1_q    <= IN_IDLE;
            sync2_q    <= IN_IDLE;
            deb_q      <= IN_IDLE;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            state_q    <= S_IDLE;
            step_cw_q  <= 1'b0;
            step_ccw_q <= 1'b0;
            c_prev_q   <= 1'b0;
            c_rise_q   <= 1'b0;
            ptr_q      <= 8'h01;
            pos_q      <= 8'h00;
            mode_q     <= 1'b0;
            led_q      <= 8'h01;
        end else begin
            sync1_q    <= {rot.ROT_CENTER, rot.ROT_B, rot.ROT_A};
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
            state_q    <= state_d;
            step_cw_q  <= step_cw_d;
            step_ccw_q <= step_ccw_d;
            c_prev_q   <= deb_q[2];
            c_rise_q   <= deb_q[2] & ~c_prev_q;
            ptr_q      <= ptr_d;
            pos_q      <= pos_d;
            mode_q     <= mode_q ^ c_rise_q;
            led_q      <= mode_q ? pos_q : ptr_q;
        end
    end

    assign rot.LED      = led_q;
    assign rot.STEP_CW  = step_cw_q;
    assign rot.STEP_CCW = step_ccw_q;
    assign rot.MODE     = mode_q;

endmodule

// File: tb/tb_rotor_led_ctrl.sv
// Directed vector bench for rotor_led_ctrl with a short debounce window.
module tb_rotor_led_ctrl;

    localparam int HOLD = 12;
    localparam int OP_RST = 0, OP_CW = 1, OP_CCW = 2, OP_PRESS = 3,
                   OP_GLITCH = 4, OP_PARTIAL = 5, OP_HOLDPRESS = 6;
`ifdef ROT_SATURATE_EN
    localparam logic [7:0] POS_BELOW_ZERO = 8'h00;
`else
    localparam logic [7:0] POS_BELOW_ZERO = 8'hFF;
`endif

    typedef struct {
        int         op;
        int         reps;
        logic [7:0] led;
        logic       mode;
        int         dcw;
        int         dccw;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    int   cw_cnt = 0;
    int   ccw_cnt = 0;
    int   both_cnt = 0;
    int   cw0, ccw0;
    vec_t tbl [18];

    rotor_led_ctrl_if rif ();

    rotor_led_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .CLK50MHZ (clk),
        .RST      (rst_n),
        .rot      (rif.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rif.STEP_CW)  cw_cnt++;
        if (rif.STEP_CCW) ccw_cnt++;
        if (rif.STEP_CW && rif.STEP_CCW) both_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic a, input logic b, input logic c, input int n);
        rif.ROT_A = a;
        rif.ROT_B = b;
        rif.ROT_CENTER = c;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic detent_cw();
        drive(0, 1, 0, HOLD);
        drive(0, 0, 0, HOLD);
        drive(1, 0, 0, HOLD);
        drive(1, 1, 0, HOLD);
    endtask

    task automatic detent_ccw();
        drive(1, 0, 0, HOLD);
        drive(0, 0, 0, HOLD);
        drive(0, 1, 0, HOLD);
        drive(1, 1, 0, HOLD);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1, 1, 0, 2);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int op, input int reps);
        case (op)
            OP_RST:       do_reset();
            OP_CW:        for (int k = 0; k < reps; k++) detent_cw();
            OP_CCW:       for (int k = 0; k < reps; k++) detent_ccw();
            OP_PRESS: begin
                drive(1, 1, 1, HOLD);
                drive(1, 1, 0, HOLD);
            end
            OP_GLITCH: begin
                drive(0, 1, 0, 2);
                drive(1, 1, 0, HOLD);
            end
            OP_PARTIAL: begin
                drive(0, 1, 0, HOLD);
                drive(1, 1, 0, HOLD);
            end
            OP_HOLDPRESS: begin
                drive(1, 1, 1, 100);
                drive(1, 1, 0, HOLD);
            end
            default: drive(1, 1, 0, HOLD);
        endcase
    endtask

    initial begin
        rif.ROT_A = 1'b1;
        rif.ROT_B = 1'b1;
        rif.ROT_CENTER = 1'b0;

        tbl[0]  = '{OP_RST,       1, 8'h01,          1'b0, 0, 0};
        tbl[1]  = '{OP_CW,        1, 8'h02,          1'b0, 1, 0};
        tbl[2]  = '{OP_CW,        7, 8'h01,          1'b0, 7, 0};
        tbl[3]  = '{OP_GLITCH,    1, 8'h01,          1'b0, 0, 0};
        tbl[4]  = '{OP_PARTIAL,   1, 8'h01,          1'b0, 0, 0};
        tbl[5]  = '{OP_CCW,       1, 8'h80,          1'b0, 0, 1};
        tbl[6]  = '{OP_PRESS,     1, 8'h07,          1'b1, 0, 0};
        tbl[7]  = '{OP_CW,        3, 8'h0A,          1'b1, 3, 0};
        tbl[8]  = '{OP_PRESS,     1, 8'h04,          1'b0, 0, 0};
        tbl[9]  = '{OP_RST,       1, 8'h01,          1'b0, 0, 0};
        tbl[10] = '{OP_CCW,       1, 8'h80,          1'b0, 0, 1};
        tbl[11] = '{OP_PRESS,     1, POS_BELOW_ZERO, 1'b1, 0, 0};
        tbl[12] = '{OP_RST,       1, 8'h01,          1'b0, 0, 0};
        tbl[13] = '{OP_PRESS,     1, 8'h00,          1'b1, 0, 0};
        tbl[14] = '{OP_CW,        3, 8'h03,          1'b1, 3, 0};
        tbl[15] = '{OP_PRESS,     1, 8'h08,          1'b0, 0, 0};
        tbl[16] = '{OP_HOLDPRESS, 1, 8'h03,          1'b1, 0, 0};
        tbl[17] = '{OP_CCW,       2, 8'h01,          1'b1, 0, 2};

        #23 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            cw0 = cw_cnt;
            ccw0 = ccw_cnt;
            run_op(tbl[i].op, tbl[i].reps);
            repeat (4) @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_led", i),  {24'd0, rif.LED}, {24'd0, tbl[i].led});
            chk($sformatf("v%0d_mode", i), {31'd0, rif.MODE}, {31'd0, tbl[i].mode});
            chk($sformatf("v%0d_cw", i),   cw_cnt - cw0, tbl[i].dcw);
            chk($sformatf("v%0d_ccw", i),  ccw_cnt - ccw0, tbl[i].dccw);
            @(posedge clk);
            #1;
        end

        // Mode 1, pointer 8'h02, position 8'h01: reset partway through a CW detent.
        drive(0, 1, 0, HOLD);
        drive(0, 0, 0, HOLD);
        #2 rst_n = 1'b0;
        #1;
        chk("async_led",  {24'd0, rif.LED}, 32'h01);
        chk("async_mode", {31'd0, rif.MODE}, 32'h0);
        chk("async_step", {30'd0, rif.STEP_CW, rif.STEP_CCW}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cw0 = cw_cnt;
        ccw0 = ccw_cnt;
        drive(1, 0, 0, HOLD);
        drive(1, 1, 0, HOLD);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("partial_reset_led",  {24'd0, rif.LED}, 32'h01);
        chk("partial_reset_step", (cw_cnt - cw0) + (ccw_cnt - ccw0), 0);
        @(posedge clk);
        #1;

        // Step and centre edge debounced together: both must take effect.
        detent_cw();
        cw0 = cw_cnt;
        drive(0, 1, 0, HOLD);
        drive(0, 0, 0, HOLD);
        drive(1, 0, 0, HOLD);
        drive(1, 1, 1, HOLD);
        drive(1, 1, 0, HOLD);
        @(negedge clk);
        chk("same_cycle_mode", {31'd0, rif.MODE}, 32'h1);
        chk("same_cycle_led",  {24'd0, rif.LED}, 32'h02);
        chk("same_cycle_cw",   cw_cnt - cw0, 1);
        @(posedge clk);
        #1;
        drive(1, 1, 1, HOLD);
        drive(1, 1, 0, HOLD);
        @(negedge clk);
        chk("pointer_kept_led", {24'd0, rif.LED}, 32'h04);
        chk("never_both_steps", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
